// File: rtl/maxpool_window_ctrl_if.sv
// Pixel-in / pooled-value-out stream pair for the 2x2 max-pool controller.
// The controller takes the slave view and the upstream/downstream side takes the master view.
interface maxpool_window_ctrl_if #(
    parameter int DATA_W = 13
) ();
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/maxpool_window_ctrl.sv
// 2x2 stride-2 max-pool sequencer: even rows leave per-column pair maxima in a line buffer,
// and odd rows merge with them to emit one pooled value per window.
module maxpool_window_ctrl #(
    parameter int INTEGER_BITS     = 9,
    parameter int FIXED_POINT_BITS = 4,
    parameter int MAP_WIDTH        = 28,
    parameter int MAP_HEIGHT       = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    maxpool_window_ctrl_if.slave  s_if
);
    localparam int DW       = INTEGER_BITS + FIXED_POINT_BITS;
    localparam int CW       = (MAP_WIDTH > 1) ? $clog2(MAP_WIDTH) : 1;
    localparam int RW       = (MAP_HEIGHT > 1) ? $clog2(MAP_HEIGHT) : 1;
    localparam int LB_DEPTH = MAP_WIDTH / 2;
    localparam int LBW      = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(MAP_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(MAP_HEIGHT - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [CW-1:0]         r_col;
    logic [RW-1:0]         r_row;
    logic signed [DW-1:0]  r_h;
    logic signed [DW-1:0]  r_out_data;
    logic                  r_out_valid;
    logic                  r_out_last;
    logic                  r_done;
    logic signed [DW-1:0]  r_linebuf [LB_DEPTH];

    logic                  w_in_ready;
    logic                  w_xfer;
    logic                  w_out_fire;
    logic                  w_odd_row;
    logic                  w_odd_col;
    logic                  w_last_pix;
    logic [LBW-1:0]        w_lb_idx;
    logic signed [DW-1:0]  w_pix;
    logic signed [DW-1:0]  w_max_hp;
    logic signed [DW-1:0]  w_lb_rd;
    logic signed [DW-1:0]  w_pool;

    assign w_odd_row  = r_row[0];
    assign w_odd_col  = r_col[0];
    assign w_last_pix = (r_row == ROW_LAST) && (r_col == COL_LAST);
    assign w_lb_idx   = LBW'(r_col >> 1);
    assign w_pix      = $signed(s_if.in_data);
    assign w_max_hp   = (w_pix > r_h) ? w_pix : r_h;
    assign w_lb_rd    = r_linebuf[w_lb_idx];
    assign w_pool     = (w_lb_rd > w_max_hp) ? w_lb_rd : w_max_hp;

    // A window-closing pixel is held off only while the previous result is still unaccepted.
    assign w_in_ready = (r_state == S_RUN) &&
                        !(w_odd_row && w_odd_col && r_out_valid && !s_if.out_ready);
    assign w_xfer     = s_if.in_valid && w_in_ready;
    assign w_out_fire = r_out_valid && s_if.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_next = S_RUN;
            S_RUN:   if (w_xfer && w_last_pix) w_state_next = S_DRAIN;
            S_DRAIN: if (w_out_fire && r_out_last) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
            r_h   <= '0;
        end else if (r_state == S_IDLE && i_start) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_xfer) begin
            if (!w_odd_col) begin
                r_h <= w_pix;
            end
            if (r_col == COL_LAST) begin
                r_col <= '0;
                r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Line buffer carries no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (w_xfer && !w_odd_row && w_odd_col) begin
            r_linebuf[w_lb_idx] <= w_max_hp;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= (r_state == S_DRAIN) && w_out_fire && r_out_last;
            if (w_xfer && w_odd_row && w_odd_col) begin
                r_out_data  <= w_pool;
                r_out_valid <= 1'b1;
                r_out_last  <= w_last_pix;
            end else if (w_out_fire) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    assign s_if.in_ready  = w_in_ready;
    assign s_if.out_data  = r_out_data;
    assign s_if.out_valid = r_out_valid;
    assign s_if.out_last  = r_out_last;
    assign o_busy         = (r_state != S_IDLE);
    assign o_done         = r_done;

endmodule

// File: tb/tb_maxpool_window_ctrl.sv
// Directed bench for maxpool_window_ctrl on a 4x4 map: reset, positive and signed frames,
// backpressure, input gaps with a stray start, and abort/restart.
module tb_maxpool_window_ctrl;
    localparam int DW = 13;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic busy;
    logic done;

    always #5 clk = ~clk;

    maxpool_window_ctrl_if #(.DATA_W(DW)) bus ();

    maxpool_window_ctrl #(
        .INTEGER_BITS(9),
        .FIXED_POINT_BITS(4),
        .MAP_WIDTH(4),
        .MAP_HEIGHT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_start(start),
        .o_busy(busy),
        .o_done(done),
        .s_if(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] got_data [$];
    logic          got_last [$];
    int            done_pulses = 0;
    int            done_misplaced = 0;
    int            busy_at_done = 0;
    logic          prev_last_xfer = 1'b0;

    logic [DW-1:0] frame_pix [16];
    logic [DW-1:0] frame_exp [4];

    // Output transfers are recorded mid-cycle; the handshake completes on the following edge.
    always @(negedge clk) begin
        if (done) begin
            done_pulses++;
            if (!prev_last_xfer) done_misplaced++;
            if (busy) busy_at_done++;
        end
        prev_last_xfer = bus.out_valid && bus.out_ready && bus.out_last;
        if (bus.out_valid && bus.out_ready) begin
            got_data.push_back(bus.out_data);
            got_last.push_back(bus.out_last);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        got_data.delete();
        got_last.delete();
        done_pulses = 0;
        done_misplaced = 0;
        busy_at_done = 0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic push(input logic [DW-1:0] d);
        int n;
        n = 0;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_frame(input bit gaps);
        for (int i = 0; i < 16; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.in_valid = 1'b0;
                    @(posedge clk); #1;
                end
                if (i == 5) begin
                    do_start();
                    chk("busy after stray start", {31'd0, busy}, 32'd1);
                end
            end
            push(frame_pix[i]);
        end
    endtask

    task automatic finish_frame(input string tag);
        int n;
        logic [31:0] obs;
        n = 0;
        while (done_pulses == 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk({tag, " done pulses"}, done_pulses, 1);
        chk({tag, " done timing"}, done_misplaced, 0);
        chk({tag, " busy at done"}, busy_at_done, 0);
        chk({tag, " busy after"}, {31'd0, busy}, 32'd0);
        chk({tag, " out count"}, got_data.size(), 4);
        for (int i = 0; i < 4; i++) begin
            obs = (i < got_data.size()) ? {19'd0, got_data[i]} : 32'hDEAD;
            chk($sformatf("%s data%0d", tag, i), obs, {19'd0, frame_exp[i]});
            obs = (i < got_last.size()) ? {31'd0, got_last[i]} : 32'hDEAD;
            chk($sformatf("%s last%0d", tag, i), obs, (i == 3) ? 32'd1 : 32'd0);
        end
        $display("frame %s: %0d outputs, %0d done pulses", tag, got_data.size(), done_pulses);
    endtask

    task automatic load_positive();
        for (int i = 0; i < 16; i++) frame_pix[i] = DW'(16 * (i + 1));
        frame_exp = '{13'h0060, 13'h0080, 13'h00E0, 13'h0100};
    endtask

    initial begin
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state and in_valid ignored while idle
        #22 rst = 1'b0;
        chk("rst out_data",  {19'd0, bus.out_data}, 32'd0);
        chk("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst out_last",  {31'd0, bus.out_last}, 32'd0);
        chk("rst done",      {31'd0, done}, 32'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = 13'h0123;
        repeat (3) begin
            @(negedge clk);
            chk("idle in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("idle busy", {31'd0, busy}, 32'd0);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;

        // Positive frame, full throughput
        clear_log();
        load_positive();
        do_start();
        chk("run busy", {31'd0, busy}, 32'd1);
        send_frame(1'b0);
        finish_frame("positive");

        // Signed frame
        clear_log();
        frame_pix = '{13'h1FF0, 13'h1FF8, 13'h1000, 13'h1000,
                      13'h1F80, 13'h1F00, 13'h1000, 13'h1000,
                      13'h1000, 13'h0000, 13'h0FFF, 13'h0001,
                      13'h1FFF, 13'h1001, 13'h0800, 13'h0FFE};
        frame_exp = '{13'h1FF8, 13'h1000, 13'h0000, 13'h0FFF};
        do_start();
        send_frame(1'b0);
        finish_frame("signed");

        // Backpressure on the first output
        clear_log();
        load_positive();
        do_start();
        for (int i = 0; i < 6; i++) push(frame_pix[i]);
        bus.out_ready = 1'b0;
        push(frame_pix[6]);
        bus.in_data  = frame_pix[7];
        bus.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("bp out_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("bp out_data", {19'd0, bus.out_data}, 32'h0060);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        for (int i = 7; i < 16; i++) push(frame_pix[i]);
        finish_frame("backpressure");

        // Input gaps plus a start pulse mid-frame
        clear_log();
        load_positive();
        do_start();
        send_frame(1'b1);
        finish_frame("gaps");

        // Abort after 6 pixels with an asynchronous mid-cycle reset
        clear_log();
        bus.out_ready = 1'b0;
        do_start();
        for (int i = 0; i < 6; i++) push(frame_pix[i]);
        chk("abort pre out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("abort pre out_data", {19'd0, bus.out_data}, 32'h0060);
        #3 rst = 1'b1;
        #1;
        chk("abort out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("abort out_data", {19'd0, bus.out_data}, 32'd0);
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort in_ready", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("abort outputs", got_data.size(), 0);
        chk("abort done", done_pulses, 0);
        clear_log();
        do_start();
        send_frame(1'b0);
        finish_frame("restart");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
